pbus_arbiter: RTL and testbench



---
 rtl/pbus_pkg.sv | 17 +
 rtl/pbus_arbiter_rr_pick2.sv | 24 ++
 rtl/pbus_arbiter.sv | 139 +++++++++++++
 tb/tb_pbus_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pbus_pkg.sv
// Shared definitions for the peripheral bus arbiter: FSM state encoding,
// master index constants and default bus widths.
package pbus_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/pbus_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin pick.
//   i_req[1:0]     eligible requests (already masked by the ack of this cycle)
//   i_last_grant   index of the master granted most recently
//   o_grant_valid  at least one request is eligible
//   o_grant_idx    chosen master; on a tie, the one that was not granted last
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_grant_valid,
  output logic       o_grant_idx
);

  always_comb begin
    o_grant_valid = |i_req;
    o_grant_idx   = 1'b0;
    case (i_req)
      2'b01:   o_grant_idx = 1'b0;
      2'b10:   o_grant_idx = 1'b1;
      2'b11:   o_grant_idx = ~i_last_grant;
      default: o_grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/pbus_arbiter.sv
// pbus_arbiter: shares the single peripheral bus between two masters
// (m0 = CPU load/store, m1 = DMA/debug). One transaction at a time,
// round-robin between the masters, fixed 3-edge latency:
//   IDLE (grant) -> ISSUE (strobe on bus) -> CAPTURE (peripheral drives
//   sys_r_line) -> IDLE with the winner's ack pulsing.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   mX_req/we/addr/wdata   master X request, held until mX_ack
//   mX_ack, mX_rdata       one-cycle completion pulse and read data
//   sys_w/sys_r            single-cycle write/read strobes
//   sys_w_addr/sys_w_line  write address/data
//   sys_r_addr, sys_r_line read address, returned read data
//   busy                   transaction in flight
// All outputs are registered.
module pbus_arbiter
  import pbus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] sys_w_addr,
  output logic [ADDR_W-1:0] sys_r_addr,
  output logic [DATA_W-1:0] sys_w_line,
  input  logic [DATA_W-1:0] sys_r_line,
  output logic              sys_w,
  output logic              sys_r,
  output logic              busy
);

  state_e r_state, w_next;
  logic   r_last_grant;
  logic   r_idx;
  logic   r_we;

  logic              w_gv, w_gi;
  logic [1:0]        w_req;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  // A master whose transfer is being acked this cycle is still holding req
  // for that finished transfer; it must not be granted again on it.
  assign w_req   = {m1_req & ~m1_ack, m0_req & ~m0_ack};
  assign w_we    = w_gi ? m1_we    : m0_we;
  assign w_addr  = w_gi ? m1_addr  : m0_addr;
  assign w_wdata = w_gi ? m1_wdata : m0_wdata;

  rr_pick2 u_pick (
    .i_req         (w_req),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_gv),
    .o_grant_idx   (w_gi)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_gv) w_next = ST_ISSUE;
      ST_ISSUE:   w_next = ST_CAPTURE;
      ST_CAPTURE: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Bus registers double as the latched address/data of the transaction,
  // so later changes on the master inputs cannot reach the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= M1;
      r_idx        <= M0;
      r_we         <= 1'b0;
      sys_w        <= 1'b0;
      sys_r        <= 1'b0;
      sys_w_addr   <= '0;
      sys_r_addr   <= '0;
      sys_w_line   <= '0;
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
      m0_rdata     <= '0;
      m1_rdata     <= '0;
      busy         <= 1'b0;
    end else begin
      busy   <= (w_next != ST_IDLE);
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_gv) begin
            r_idx        <= w_gi;
            r_we         <= w_we;
            r_last_grant <= w_gi;
            if (w_we) begin
              sys_w      <= 1'b1;
              sys_w_addr <= w_addr;
              sys_w_line <= w_wdata;
            end else begin
              sys_r      <= 1'b1;
              sys_r_addr <= w_addr;
            end
          end
        end
        ST_ISSUE: begin
          sys_w <= 1'b0;
          sys_r <= 1'b0;
        end
        ST_CAPTURE: begin
          if (r_idx == M0) begin
            m0_ack <= 1'b1;
            if (!r_we) m0_rdata <= sys_r_line;
          end else begin
            m1_ack <= 1'b1;
            if (!r_we) m1_rdata <= sys_r_line;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pbus_arbiter.sv
module tb_pbus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic        m0_ack, m1_ack, sys_w, sys_r, busy;
  logic [31:0] m0_rdata, m1_rdata, sys_w_addr, sys_r_addr, sys_w_line;
  logic [31:0] sys_r_line = 32'hDEADBEEF;
  logic [31:0] rd_val = '0;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  // Peripheral model: drives the read data in the cycle after the strobe,
  // garbage otherwise so a mistimed capture is visible.
  always @(posedge clk) sys_r_line <= sys_r ? rd_val : 32'hDEADBEEF;

  pbus_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .sys_w_addr(sys_w_addr), .sys_r_addr(sys_r_addr), .sys_w_line(sys_w_line),
    .sys_r_line(sys_r_line), .sys_w(sys_w), .sys_r(sys_r), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vecs++; if ({sys_w, sys_r, m0_ack, m1_ack, busy} !== 5'b0) begin errs++; $display("FAIL reset_ctl got %b exp 00000", {sys_w, sys_r, m0_ack, m1_ack, busy}); end
    vecs++; if ({sys_w_addr, sys_r_addr, sys_w_line} !== 96'h0) begin errs++; $display("FAIL reset_bus got %h exp 0", {sys_w_addr, sys_r_addr, sys_w_line}); end
    vecs++; if ({m0_rdata, m1_rdata} !== 64'h0) begin errs++; $display("FAIL reset_rdata got %h exp 0", {m0_rdata, m1_rdata}); end
    rst = 1'b0;
  endtask

  task automatic test_m0_read();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40; rd_val = 32'h00A5;
    tick(); // E0: grant
    vecs++; if ({sys_r, sys_w, busy} !== 3'b101) begin errs++; $display("FAIL rd_strobe got %b exp 101", {sys_r, sys_w, busy}); end
    vecs++; if (sys_r_addr !== 32'h40) begin errs++; $display("FAIL rd_addr got %h exp 00000040", sys_r_addr); end
    tick(); // E1
    vecs++; if ({sys_r, m0_ack} !== 2'b00) begin errs++; $display("FAIL rd_strobe_1cyc got %b exp 00", {sys_r, m0_ack}); end
    tick(); // E2: ack
    vecs++; if ({m0_ack, m1_ack, busy} !== 3'b100) begin errs++; $display("FAIL rd_ack got %b exp 100", {m0_ack, m1_ack, busy}); end
    vecs++; if (m0_rdata !== 32'h00A5) begin errs++; $display("FAIL rd_data got %h exp 000000a5", m0_rdata); end
    m0_req = 1'b0;
    tick();
    vecs++; if ({m0_ack, sys_r, busy} !== 3'b000) begin errs++; $display("FAIL rd_ack_pulse got %b exp 000", {m0_ack, sys_r, busy}); end
  endtask

  task automatic test_m1_write();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h41; m1_wdata = 32'hFFFF0000;
    tick();
    vecs++; if ({sys_w, sys_r} !== 2'b10) begin errs++; $display("FAIL wr_strobe got %b exp 10", {sys_w, sys_r}); end
    vecs++; if ({sys_w_addr, sys_w_line} !== {32'h41, 32'hFFFF0000}) begin errs++; $display("FAIL wr_bus got %h exp 00000041ffff0000", {sys_w_addr, sys_w_line}); end
    tick();
    vecs++; if ({sys_w, sys_r} !== 2'b00) begin errs++; $display("FAIL wr_strobe_1cyc got %b exp 00", {sys_w, sys_r}); end
    tick();
    vecs++; if ({m1_ack, m0_ack, sys_r} !== 3'b100) begin errs++; $display("FAIL wr_ack got %b exp 100", {m1_ack, m0_ack, sys_r}); end
    m1_req = 1'b0;
    tick();
    vecs++; if ({m1_ack, sys_w, sys_r} !== 3'b000) begin errs++; $display("FAIL wr_ack_pulse got %b exp 000", {m1_ack, sys_w, sys_r}); end
  endtask

  task automatic test_tie();
    test_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20;
    rd_val = 32'h1111;
    tick(); // E0: m0 wins the first tie
    vecs++; if ({sys_r, sys_r_addr} !== {1'b1, 32'h10}) begin errs++; $display("FAIL tie_first got %h exp 100000010", {sys_r, sys_r_addr}); end
    tick();
    tick(); // E2: m0 ack, m1 granted on this cycle's closing edge
    vecs++; if ({m0_ack, m1_ack, m0_rdata} !== {2'b10, 32'h1111}) begin errs++; $display("FAIL tie_m0_ack got %h exp 200001111", {m0_ack, m1_ack, m0_rdata}); end
    m0_req = 1'b0; rd_val = 32'h2222;
    tick(); // E3: m1 strobe, 3 cycles after m0's
    vecs++; if ({sys_r, sys_r_addr} !== {1'b1, 32'h20}) begin errs++; $display("FAIL tie_second got %h exp 100000020", {sys_r, sys_r_addr}); end
    tick();
    tick(); // E5: m1 ack
    vecs++; if ({m1_ack, m0_ack, m1_rdata} !== {2'b10, 32'h2222}) begin errs++; $display("FAIL tie_m1_ack got %h exp 200002222", {m1_ack, m0_ack, m1_rdata}); end
    vecs++; if (m0_rdata !== 32'h1111) begin errs++; $display("FAIL tie_m0_hold got %h exp 00001111", m0_rdata); end
    m1_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int wcnt = 0, acnt = 0;
    logic prev_ack = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h80; m0_wdata = 32'hA0;
    for (int i = 0; i < 30; i++) begin
      tick();
      // a grant on the ack cycle would duplicate the finished write
      if (prev_ack) begin
        vecs++; if (sys_w !== 1'b0) begin errs++; $display("FAIL b2b_dup_write cyc %0d got %b exp 0", i, sys_w); end
      end
      if (sys_w) wcnt++;
      prev_ack = m0_ack;
      if (m0_ack) begin
        acnt++;
        if (acnt == 3) begin
          m0_req = 1'b0;
          break;
        end
      end
    end
    vecs++; if (acnt != 3) begin errs++; $display("FAIL b2b_acks got %0d exp 3", acnt); end
    tick();
    tick();
    vecs++; if (wcnt != 3 || sys_w !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL b2b_writes got %0d/%b/%b exp 3/0/0", wcnt, sys_w, busy); end
  endtask

  task automatic test_reset_mid();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h30; rd_val = 32'h7777;
    tick(); // ISSUE
    tick(); // CAPTURE
    vecs++; if ({busy, sys_r} !== 2'b10) begin errs++; $display("FAIL rm_capture got %b exp 10", {busy, sys_r}); end
    rst = 1'b1;
    tick();
    vecs++; if ({busy, sys_r, sys_w, m0_ack, m1_ack} !== 5'b0) begin errs++; $display("FAIL rm_ctl got %b exp 00000", {busy, sys_r, sys_w, m0_ack, m1_ack}); end
    vecs++; if ({m0_rdata, m1_rdata, sys_r_addr, sys_w_addr, sys_w_line} !== 160'h0) begin errs++; $display("FAIL rm_data got %h exp 0", {m0_rdata, m1_rdata, sys_r_addr}); end
    rst = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h50; m0_wdata = 32'h5;
    tick();
    vecs++; if ({sys_w, sys_r, sys_w_addr} !== {2'b10, 32'h50}) begin errs++; $display("FAIL rm_m0_first got %h exp 200000050", {sys_w, sys_r, sys_w_addr}); end
    vecs++; if (m1_ack !== 1'b0) begin errs++; $display("FAIL rm_no_m1_ack got %b exp 0", m1_ack); end
    m0_req = 1'b0; m1_req = 1'b0;
    test_reset();
  endtask

  task automatic test_drop_after_grant();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h60; m0_wdata = 32'hCAFE0001;
    tick(); // ISSUE
    m0_req = 1'b0; m0_wdata = 32'h1234; m0_addr = 32'h99; m0_we = 1'b0;
    vecs++; if ({sys_w, sys_w_line} !== {1'b1, 32'hCAFE0001}) begin errs++; $display("FAIL drop_issue got %h exp 1cafe0001", {sys_w, sys_w_line}); end
    tick(); // CAPTURE
    vecs++; if ({sys_w_addr, sys_w_line} !== {32'h60, 32'hCAFE0001}) begin errs++; $display("FAIL drop_hold got %h exp 00000060cafe0001", {sys_w_addr, sys_w_line}); end
    tick(); // ack
    vecs++; if ({m0_ack, m1_ack} !== 2'b10) begin errs++; $display("FAIL drop_ack got %b exp 10", {m0_ack, m1_ack}); end
    tick();
    vecs++; if ({m0_ack, sys_w, sys_r, busy} !== 4'b0) begin errs++; $display("FAIL drop_idle got %b exp 0000", {m0_ack, sys_w, sys_r, busy}); end
  endtask

  initial begin
    test_reset();
    test_m0_read();
    test_m1_write();
    test_tie();
    test_back_to_back();
    test_reset_mid();
    test_drop_after_grant();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
